// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver: hunts for one of NUM_TYPES headers, forwards the type's payload bytes.
// Optional trailing checksum verification with FRAME_CHECKSUM_EN.
module serial_frame_receiver #(
   parameter int NUM_TYPES = 2,
   parameter int HEADER_LEN = 5,
   parameter logic [NUM_TYPES*HEADER_LEN*8-1:0] HEADERS = "FGHIJABCDE",
   parameter logic [NUM_TYPES*16-1:0] PAYLOAD_LENS = {16'd16, 16'd8},
   parameter int TIMEOUT_CYCLES = 48000,
   localparam int TYPE_W = (NUM_TYPES > 1) ? $clog2(NUM_TYPES) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [7:0]           rx_data,
   input  logic                 rx_data_ready,
   output logic [7:0]           msg_out,
   output logic                 data_valid,
   output logic [TYPE_W-1:0]    msg_type,
   output logic [NUM_TYPES-1:0] type_flags,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 frame_error
);
   localparam int WIN_W = HEADER_LEN * 8;
   typedef enum logic [1:0] {
      HUNT,
`ifdef FRAME_CHECKSUM_EN
      CHECK,
`endif
      PAYLOAD
   } state_t;
   state_t                 r_state, w_state_n;
   logic [WIN_W-1:0]       r_win, w_win_n, w_win_sh;
   logic [3:0]             r_fill, w_fill_n, w_fill_sh;
   logic [15:0]            r_cnt, w_cnt_n;
   logic [23:0]            r_idle, w_idle_n;
   logic [TYPE_W-1:0]      r_type, w_type_n, w_hit_type;
   logic [NUM_TYPES-1:0]   r_flags, w_flags_n;
   logic [7:0]             r_msg, w_msg_n;
   logic                   r_valid, w_valid_n, r_done, w_done_n, r_err, w_err_n;
   logic                   w_hit, w_timeout;
`ifdef FRAME_CHECKSUM_EN
   logic [7:0]             r_sum, w_sum_n;
`endif
   assign w_win_sh  = WIN_W'({r_win, rx_data});
   assign w_fill_sh = (r_fill == 4'(HEADER_LEN)) ? r_fill : r_fill + 4'd1;
   assign w_timeout = (TIMEOUT_CYCLES != 0) && !rx_data_ready && (r_idle == 24'(TIMEOUT_CYCLES - 1));
   // Descending scan so the lowest-index matching type is the one left standing.
   always_comb begin
      w_hit = 1'b0;
      w_hit_type = '0;
      for (int i = NUM_TYPES - 1; i >= 0; i--)
         if (w_win_sh == HEADERS[i*WIN_W +: WIN_W]) begin
            w_hit = 1'b1;
            w_hit_type = TYPE_W'(i);
         end
   end
   always_comb begin
      w_state_n = r_state;
      w_win_n   = r_win;
      w_fill_n  = r_fill;
      w_cnt_n   = r_cnt;
      w_idle_n  = (r_state != HUNT && !rx_data_ready) ? r_idle + 24'd1 : '0;
      w_type_n  = r_type;
      w_flags_n = (r_done || r_err) ? '0 : r_flags;
      w_msg_n   = r_msg;
      w_valid_n = 1'b0;
      w_done_n  = 1'b0;
      w_err_n   = 1'b0;
`ifdef FRAME_CHECKSUM_EN
      w_sum_n   = r_sum;
`endif
      case (r_state)
         HUNT: if (rx_data_ready) begin
            w_win_n  = w_win_sh;
            w_fill_n = w_fill_sh;
            if (w_fill_sh == 4'(HEADER_LEN) && w_hit) begin
               w_state_n = PAYLOAD;
               w_type_n  = w_hit_type;
               w_flags_n = NUM_TYPES'(1) << w_hit_type;
               w_cnt_n   = PAYLOAD_LENS[int'(w_hit_type)*16 +: 16];
               w_win_n   = '0;
               w_fill_n  = '0;
`ifdef FRAME_CHECKSUM_EN
               w_sum_n   = '0;
`endif
            end
         end
         PAYLOAD: if (rx_data_ready) begin
            w_msg_n   = rx_data;
            w_valid_n = 1'b1;
            w_cnt_n   = r_cnt - 16'd1;
`ifdef FRAME_CHECKSUM_EN
            w_sum_n   = r_sum + rx_data;
            if (r_cnt == 16'd1) w_state_n = CHECK;
`else
            if (r_cnt == 16'd1) begin
               w_done_n  = 1'b1;
               w_state_n = HUNT;
            end
`endif
         end
`ifdef FRAME_CHECKSUM_EN
         CHECK: if (rx_data_ready) begin
            w_done_n  = (rx_data == r_sum);
            w_err_n   = (rx_data != r_sum);
            w_state_n = HUNT;
         end
`endif
         default: w_state_n = HUNT;
      endcase
      if (r_state != HUNT && w_timeout) begin
         w_err_n   = 1'b1;
         w_state_n = HUNT;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= HUNT;
         r_win   <= '0;
         r_fill  <= '0;
         r_cnt   <= '0;
         r_idle  <= '0;
         r_type  <= '0;
         r_flags <= '0;
         r_msg   <= '0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
         r_sum   <= '0;
`endif
      end else begin
         r_state <= w_state_n;
         r_win   <= w_win_n;
         r_fill  <= w_fill_n;
         r_cnt   <= w_cnt_n;
         r_idle  <= w_idle_n;
         r_type  <= w_type_n;
         r_flags <= w_flags_n;
         r_msg   <= w_msg_n;
         r_valid <= w_valid_n;
         r_done  <= w_done_n;
         r_err   <= w_err_n;
`ifdef FRAME_CHECKSUM_EN
         r_sum   <= w_sum_n;
`endif
      end
   end
   assign msg_out     = r_msg;
   assign data_valid  = r_valid;
   assign msg_type    = r_type;
   assign type_flags  = r_flags;
   assign busy        = (r_state != HUNT);
   assign frame_done  = r_done;
   assign frame_error = r_err;
endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb_serial_frame_receiver: directed and randomized frames checked against a stream-level reference model.
// Honours FRAME_CHECKSUM_EN the same way as the design.
module tb_serial_frame_receiver;
   typedef logic [7:0] bq_t[$];
   localparam int HL = 5;
   localparam int T_OUT = 48000;
   logic clk = 1'b0, reset, rx_data_ready;
   logic [7:0] rx_data, msg_out;
   logic data_valid, busy, frame_done, frame_error;
   logic [0:0] msg_type;
   logic [1:0] type_flags;
   serial_frame_receiver dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_data_ready(rx_data_ready),
      .msg_out(msg_out), .data_valid(data_valid), .msg_type(msg_type), .type_flags(type_flags),
      .busy(busy), .frame_done(frame_done), .frame_error(frame_error)
   );
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   string hdr[2] = '{"ABCDE", "FGHIJ"};
   int plen[2] = '{8, 16};
   int n_chk = 0, n_pass = 0, n_fail = 0;
   logic [7:0] got_b[$];
   int got_t[$], got_f[$];
   int n_done, n_err, done_cyc, err_cyc, last_cyc;
   logic [7:0] exp_b[$];
   int exp_t[$];
   int exp_done, exp_err;
   bq_t s;
   always @(negedge clk) if (!reset) begin
      if (data_valid) begin
         got_b.push_back(msg_out);
         got_t.push_back(int'(msg_type));
         got_f.push_back(int'(type_flags));
      end
      if (frame_done) begin n_done++; done_cyc = cyc; end
      if (frame_error) begin n_err++; err_cyc = cyc; end
   end
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   function automatic int match_at(input bq_t q, input int start, input int k);
      bit ok;
      if (k - start + 1 < HL) return -1;
      for (int t = 0; t < 2; t++) begin
         ok = 1;
         for (int j = 0; j < HL; j++) if (q[k-HL+1+j] != hdr[t][j]) ok = 0;
         if (ok) return t;
      end
      return -1;
   endfunction
   // Walk the byte stream: hunt for a full header, then take the type's payload (and checksum byte).
   task automatic model(input bq_t q);
      int k, start, t, n;
      logic [7:0] sum;
      exp_b.delete(); exp_t.delete(); exp_done = 0; exp_err = 0;
      k = 0; start = 0;
      while (k < q.size()) begin
         t = match_at(q, start, k);
         k++;
         if (t >= 0) begin
            n = 0; sum = 0;
            while (n < plen[t] && k < q.size()) begin
               exp_b.push_back(q[k]); exp_t.push_back(t); sum += q[k]; n++; k++;
            end
            if (n == plen[t]) begin
`ifdef FRAME_CHECKSUM_EN
               if (k < q.size()) begin
                  if (q[k] == sum) exp_done++; else exp_err++;
                  k++;
               end
`else
               exp_done++;
`endif
            end
            start = k;
         end
      end
   endtask
   task automatic clear_mon();
      got_b.delete(); got_t.delete(); got_f.delete();
      n_done = 0; n_err = 0; done_cyc = -1; err_cyc = -1;
   endtask
   task automatic send(input bq_t q);
      foreach (q[i]) begin
         rx_data = q[i]; rx_data_ready = 1'b1; last_cyc = cyc;
         @(negedge clk);
      end
      rx_data_ready = 1'b0;
   endtask
   task automatic push_str(input string h);
      for (int j = 0; j < h.len(); j++) s.push_back(h[j]);
   endtask
   task automatic push_frame(input int t, input bit bad);
      logic [7:0] b, sum;
      sum = 0;
      push_str(hdr[t]);
      for (int j = 0; j < plen[t]; j++) begin b = 8'($urandom); sum += b; s.push_back(b); end
`ifdef FRAME_CHECKSUM_EN
      s.push_back(bad ? sum + 8'd1 : sum);
`else
      if (bad) sum = 0;
`endif
   endtask
   task automatic run_frame(input string tag);
      clear_mon();
      model(s);
      send(s);
      repeat (4) @(negedge clk);
      check({tag, " count"}, got_b.size(), exp_b.size());
      for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
         check({tag, " byte"}, got_b[i], exp_b[i]);
         check({tag, " type"}, got_t[i], exp_t[i]);
         check({tag, " flags"}, got_f[i], 1 << exp_t[i]);
      end
      check({tag, " done"}, n_done, exp_done);
      check({tag, " err"}, n_err, exp_err);
      if (exp_done + exp_err > 0)
         check({tag, " end latency"}, (exp_done > 0) ? done_cyc : err_cyc, last_cyc + 1);
      check({tag, " flags idle"}, type_flags, 0);
      check({tag, " busy idle"}, busy, 0);
   endtask
   task automatic check_zero(input string tag);
      check({tag, " msg_out"}, msg_out, 0);
      check({tag, " valid"}, data_valid, 0);
      check({tag, " msg_type"}, msg_type, 0);
      check({tag, " flags"}, type_flags, 0);
      check({tag, " busy"}, busy, 0);
      check({tag, " done"}, frame_done, 0);
      check({tag, " err"}, frame_error, 0);
   endtask
   initial begin
      int w;
      reset = 1'b1; rx_data_ready = 1'b0; rx_data = 8'h00;
      clear_mon();
      repeat (3) @(negedge clk);
      check_zero("reset");
      reset = 1'b0;
      @(negedge clk);
      s = {}; push_str("ABCDE");
      for (int j = 1; j <= 8; j++) s.push_back(8'(j));
`ifdef FRAME_CHECKSUM_EN
      s.push_back(8'd36);
`endif
      run_frame("seq");
      s = {}; push_str("XX"); push_frame(1, 0);
      run_frame("xx_type1");
      check("msg_type held", msg_type, 1);
      s = {}; push_str("A"); push_frame(0, 0);
      run_frame("slide");
      for (int r = 0; r < 6; r++) begin
         s = {};
         repeat ($urandom_range(0, 6)) s.push_back(8'($urandom_range(0, 63)));
         push_frame($urandom_range(0, 1), $urandom_range(0, 3) == 0);
         push_frame($urandom_range(0, 1), $urandom_range(0, 3) == 0);
         run_frame("rand");
      end
`ifdef FRAME_CHECKSUM_EN
      s = {}; push_str("ABCDE");
      repeat (8) s.push_back(8'h10);
      s.push_back(8'h80);
      run_frame("csum_ok");
      check("csum_ok fwd", got_b.size(), 8);
      check("csum_ok done", n_done, 1);
      s[s.size()-1] = 8'h81;
      run_frame("csum_bad");
      check("csum_bad fwd", got_b.size(), 8);
      check("csum_bad err", n_err, 1);
`endif
      clear_mon();
      s = {}; push_str("ABCDE");
      repeat (3) s.push_back(8'($urandom));
      send(s);
      w = 0;
      while (!frame_error && w < T_OUT + 100) begin @(negedge clk); w++; end
      check("timeout cycles", w, T_OUT);
      repeat (4) @(negedge clk);
      check("timeout err", n_err, 1);
      check("timeout done", n_done, 0);
      check("timeout fwd", got_b.size(), 3);
      check("timeout flags", type_flags, 0);
      check("timeout busy", busy, 0);
      s = {}; push_frame(0, 0);
      run_frame("after_timeout");
      clear_mon();
      s = {}; push_str("FGHIJ");
      repeat (3) s.push_back(8'($urandom));
      send(s);
      @(negedge clk);
      check("mid busy", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      check_zero("mid reset");
      reset = 1'b0;
      s = {}; repeat (5) s.push_back(8'h00);
      send(s);
      repeat (4) @(negedge clk);
      check("post reset fwd", got_b.size(), 3);
      check("post reset done", n_done, 0);
      s = {}; push_frame(1, 0);
      run_frame("after_reset");
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/serial_frame_receiver.md
# serial_frame_receiver

- Parametrised multi-type framed message receiver that sits between `serial_rx` and downstream consumers (particle and map loaders, `serial_tx` echo path).
- Hunts the RX byte stream for any of `NUM_TYPES` fixed start headers, then forwards exactly that type's payload length of bytes, tagged with the type.
- Aborts a stalled frame on an inter-byte timeout.
- Optionally verifies a trailing checksum byte.

## Interface
- `NUM_TYPES`, 2, number of message types (1–8); `TYPE_W = max(1, $clog2(NUM_TYPES))`.
- `HEADER_LEN`, 5, header length in bytes, shared by all types (1–8).
- `HEADERS`, "FGHIJABCDE", `NUM_TYPES*HEADER_LEN*8` bits.
  - Type i occupies bits [(i+1)\*HEADER_LEN\*8-1 : i\*HEADER_LEN\*8].
  - The first received byte is the MSB of its slice. The default gives type 0 = "ABCDE" and type 1 = "FGHIJ".
- `PAYLOAD_LENS`, {16'd16,16'd8}, `NUM_TYPES*16` bits.
  - Type i payload length is bits [16i+15:16i], in the range 1–65535.
- `TIMEOUT_CYCLES`, 48000, idle clocks allowed between bytes inside a frame (24-bit counter). 0 disables the timeout.
- `clk` in 1, system clock.
- `reset` in 1, synchronous, active-high.
- `rx_data` in 8, byte from `serial_rx`.
- `rx_data_ready` in 1, single-cycle strobe; `rx_data` is valid in the same cycle.
- `msg_out` out 8, payload byte.
- `data_valid` out 1, single-cycle strobe qualifying `msg_out`.
- `msg_type` out TYPE_W, type of the current frame.
- `type_flags` out NUM_TYPES, one-hot and high while a frame of that type is active.
- `busy` out 1, high in PAYLOAD or CHECK.
- `frame_done` out 1, single-cycle pulse on a completed frame.
- `frame_error` out 1, single-cycle pulse on timeout or checksum mismatch.

## Operation
- States: HUNT, PAYLOAD, CHECK. The CHECK state exists only with the macro defined.
- HUNT:
  - Each strobe shifts `rx_data` into a HEADER_LEN-byte window and increments a fill counter that saturates at HEADER_LEN.
  - When the fill counter equals HEADER_LEN after the shift, the window is compared against every header. If several headers match, the lowest-index type wins.
  - On a match, latch the type and load the byte counter with that type's length. Go to PAYLOAD.
  - Header bytes are never forwarded.
  - Overlapping prefixes are matched correctly because the window slides. For example, "AABCDE" matches type 0.
- PAYLOAD:
  - Each strobe drives `msg_out <= rx_data` and `data_valid <= 1`, then decrements the byte counter.
  - After the last payload byte, go to CHECK if the macro is defined; otherwise pulse `frame_done` and return to HUNT.
- Return to HUNT, by any path, clears the window and the fill counter.
- `msg_type` and `type_flags` are set in the cycle after the header match. They hold until the cycle after `frame_done` or `frame_error`, then `type_flags` returns to 0. `msg_type` keeps its last value.
- Timeout:
  - In PAYLOAD and CHECK, the idle counter resets on every strobe and otherwise increments.
  - When the counter reaches TIMEOUT_CYCLES, pulse `frame_error` and return to HUNT. No `frame_done` is produced.
  - If a strobe arrives in the expiry cycle, the byte wins and the timeout does not fire.
- `reset` has priority over everything. It puts the block in HUNT with the window cleared.
- Reset values: all outputs are 0, and `msg_type` is 0.

## Timing
- Latency is 1 clock from the `rx_data_ready` strobe to `data_valid`/`msg_out`, and 1 clock from the final byte's strobe to `frame_done` or `frame_error`.
- `msg_out` holds its value between strobes.
- Strobes may arrive back-to-back on consecutive cycles. One byte is accepted per cycle, with no backpressure.
- The byte counter is 16 bits. There is no wrap because the counter stops at 0.

## Configuration
- Macro: `FRAME_CHECKSUM_EN`.
- When defined:
  - Each frame carries one extra byte after the payload. That byte must equal the 8-bit modulo-256 sum of the payload bytes; the header is excluded.
  - The checksum byte is consumed in CHECK and is not forwarded.
  - On a match, pulse `frame_done`. On a mismatch, pulse `frame_error`. Either way, return to HUNT.
  - The running sum clears on header match.
- When undefined:
  - No CHECK state and no sum logic.
  - `frame_error` fires only on timeout.

## Test plan
- Default parameters, macro off. Send "ABCDE" followed by bytes 0x01..0x08 back-to-back → 8 `data_valid` pulses with `msg_out` 0x01..0x08. `type_flags`=2'b01 during the frame. `frame_done` pulses 1 clock after the 8th strobe.
- Send "XXFGHIJ" followed by 16 bytes → no output for the leading "XXFGHIJ" bytes. `msg_type`=1 and `type_flags`=2'b10. Exactly 16 `data_valid` pulses, then `frame_done`.
- Send "AABCDE" followed by 8 bytes → the frame matches type 0, proving sliding-window matching.
- Send "ABCDE" and 3 payload bytes, then idle 48000 clocks → `frame_error` at expiry, no `frame_done`. A subsequent "ABCDE" frame is received normally.
- Macro on. Send "ABCDE", 0x10×8, then 0x80 → `frame_done`. Repeat with 0x81 as the last byte → `frame_error`. Neither run forwards the checksum byte.
- Assert `reset` for 1 cycle in the middle of a payload → all outputs go to 0. The remaining bytes of the interrupted frame produce no `data_valid`.
